// File: rtl/sargantana_icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// sargantana_icache_refill_ctrl
//
// Instruction-cache miss/refill controller. Takes one miss at a time, issues
// a line request to the next memory level, and on the response picks a victim
// way (the lowest invalid way, or the LFSR way when the set is full). It then
// writes the line into the cache arrays. The LFSR is advanced only when its
// way was actually used for a write.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              kill any in-flight refill (no array write)
//   miss_*               miss request handshake (idx/tag of the missing line)
//   valid_bits_i         valid bits of set refill_idx_o, read from tag array
//   lfsr_way_i/lfsr_en_o pseudo-random way input / one-cycle advance pulse
//   mem_req_*            line request to memory, address = {tag, idx}
//   mem_rsp_*            line response (always accepted), with bus error flag
//   refill_we_o ...      array write strobe, way/idx/tag/data written
//   refill_done_o/err_o  one-cycle completion pulse, err = nothing written
//   busy_o               controller not idle
// ---------------------------------------------------------------------------
module sargantana_icache_refill_ctrl #(
    parameter  int unsigned ICACHE_N_WAY = 4,
    parameter  int unsigned IDX_W        = 6,
    parameter  int unsigned TAG_W        = 20,
    parameter  int unsigned LINE_W       = 128,
    localparam int unsigned WAY_W        = $clog2(ICACHE_N_WAY)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,

    input  logic                    miss_valid_i,
    input  logic [IDX_W-1:0]        miss_idx_i,
    input  logic [TAG_W-1:0]        miss_tag_i,
    output logic                    miss_ready_o,

    input  logic [ICACHE_N_WAY-1:0] valid_bits_i,
    input  logic [WAY_W-1:0]        lfsr_way_i,
    output logic                    lfsr_en_o,

    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [TAG_W+IDX_W-1:0]  mem_req_addr_o,

    input  logic                    mem_rsp_valid_i,
    input  logic                    mem_rsp_err_i,
    input  logic [LINE_W-1:0]       mem_rsp_data_i,

    output logic                    refill_we_o,
    output logic [WAY_W-1:0]        refill_way_o,
    output logic [IDX_W-1:0]        refill_idx_o,
    output logic [TAG_W-1:0]        refill_tag_o,
    output logic [LINE_W-1:0]       refill_data_o,
    output logic                    refill_done_o,
    output logic                    refill_err_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t              r_state;
    logic                r_kill;       // flush seen while the request was pending
    logic                r_req_valid;
    logic                r_we;
    logic                r_lfsr_en;
    logic                r_busy;
    logic [WAY_W-1:0]    r_way;
    logic [IDX_W-1:0]    r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic [LINE_W-1:0]   r_data;

    logic [WAY_W-1:0]    w_victim_way;
    logic                w_victim_lfsr;
    logic                w_found_invalid;
    logic                w_rsp_err_done;

    // Victim: lowest-index invalid way; the LFSR way only when the set is full.
    always_comb begin
        w_victim_way    = lfsr_way_i;
        w_victim_lfsr   = 1'b1;
        w_found_invalid = 1'b0;
        for (int unsigned i = 0; i < ICACHE_N_WAY; i++) begin
            if (!w_found_invalid && !valid_bits_i[i]) begin
                w_victim_way    = WAY_W'(i);
                w_victim_lfsr   = 1'b0;
                w_found_invalid = 1'b1;
            end
        end
    end

    // Error completion is signalled in the response cycle itself, so it cannot
    // come from a register; a same-cycle flush suppresses it.
    assign w_rsp_err_done = (r_state == S_WAIT) && mem_rsp_valid_i &&
                            mem_rsp_err_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_way       <= '0;
            r_idx       <= '0;
            r_tag       <= '0;
            r_data      <= '0;
        end else begin
            r_we      <= 1'b0;
            r_lfsr_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (miss_valid_i && !flush_i) begin
                        r_idx       <= miss_idx_i;
                        r_tag       <= miss_tag_i;
                        r_kill      <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The request is never withdrawn; a flush only marks the
                    // eventual response for discarding.
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_kill      <= 1'b0;
                        r_state     <= (flush_i || r_kill) ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        if (mem_rsp_valid_i) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_data    <= mem_rsp_data_i;
                            r_way     <= w_victim_way;
                            r_we      <= 1'b1;
                            r_lfsr_en <= w_victim_lfsr;
                            r_state   <= S_WRITE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_req_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign miss_ready_o    = (r_state == S_IDLE) && !flush_i;
    assign mem_req_valid_o = r_req_valid;
    assign mem_req_addr_o  = {r_tag, r_idx};
    assign refill_we_o     = r_we;
    assign refill_way_o    = r_way;
    assign refill_idx_o    = r_idx;
    assign refill_tag_o    = r_tag;
    assign refill_data_o   = r_data;
    assign refill_done_o   = r_we || w_rsp_err_done;
    assign refill_err_o    = w_rsp_err_done;
    assign lfsr_en_o       = r_lfsr_en;
    assign busy_o          = r_busy;

    // Only one request is ever outstanding, so a response is legal only while
    // waiting for it or draining it.
    a_rsp_in_window: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> (r_state == S_WAIT || r_state == S_DRAIN)
    );

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
module tb_sargantana_icache_refill_ctrl;

    localparam int N_WAY  = 4;
    localparam int WAY_W  = 2;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 20;
    localparam int LINE_W = 128;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic                   miss_valid_i;
    logic [IDX_W-1:0]       miss_idx_i;
    logic [TAG_W-1:0]       miss_tag_i;
    logic                   miss_ready_o;
    logic [N_WAY-1:0]       valid_bits_i;
    logic [WAY_W-1:0]       lfsr_way_i;
    logic                   lfsr_en_o;
    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [TAG_W+IDX_W-1:0] mem_req_addr_o;
    logic                   mem_rsp_valid_i;
    logic                   mem_rsp_err_i;
    logic [LINE_W-1:0]      mem_rsp_data_i;
    logic                   refill_we_o;
    logic [WAY_W-1:0]       refill_way_o;
    logic [IDX_W-1:0]       refill_idx_o;
    logic [TAG_W-1:0]       refill_tag_o;
    logic [LINE_W-1:0]      refill_data_o;
    logic                   refill_done_o;
    logic                   refill_err_o;
    logic                   busy_o;

    sargantana_icache_refill_ctrl #(
        .ICACHE_N_WAY(N_WAY),
        .IDX_W       (IDX_W),
        .TAG_W       (TAG_W),
        .LINE_W      (LINE_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .miss_valid_i   (miss_valid_i),
        .miss_idx_i     (miss_idx_i),
        .miss_tag_i     (miss_tag_i),
        .miss_ready_o   (miss_ready_o),
        .valid_bits_i   (valid_bits_i),
        .lfsr_way_i     (lfsr_way_i),
        .lfsr_en_o      (lfsr_en_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_err_i  (mem_rsp_err_i),
        .mem_rsp_data_i (mem_rsp_data_i),
        .refill_we_o    (refill_we_o),
        .refill_way_o   (refill_way_o),
        .refill_idx_o   (refill_idx_o),
        .refill_tag_o   (refill_tag_o),
        .refill_data_o  (refill_data_o),
        .refill_done_o  (refill_done_o),
        .refill_err_o   (refill_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 normal, 1 flush while request pending, 2 flush in WAIT before
    // the response, 3 flush in the same cycle as the response
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic [N_WAY-1:0]  vb;
        logic [WAY_W-1:0]  lfsr;
        bit                err;
        logic [LINE_W-1:0] data;
        int                kind;
        int                req_wait;
        int                flush_at;
        int                rsp_wait;
    } txn_t;

    typedef struct {
        bit                we;
        bit                err;
        bit                lfsr_en;
        logic [WAY_W-1:0]  way;
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [TAG_W-1:0] last_tag = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Victim choice from the rule: first invalid way in index order, else LFSR.
    function automatic void pick_way(input logic [N_WAY-1:0] vb, input logic [WAY_W-1:0] lfsr,
                                     output logic [WAY_W-1:0] way, output bit used_lfsr);
        int inv[$];
        for (int i = 0; i < N_WAY; i++)
            if (vb[i] == 1'b0) inv.push_back(i);
        if (inv.size() > 0) begin
            way       = WAY_W'(inv[0]);
            used_lfsr = 1'b0;
        end else begin
            way       = lfsr;
            used_lfsr = 1'b1;
        end
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every completion/write/LFSR event must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && (refill_done_o || refill_we_o || refill_err_o || lfsr_en_o)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 128'({refill_we_o, refill_done_o, refill_err_o, lfsr_en_o}), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_ctrl", 128'({refill_we_o, refill_done_o, refill_err_o, lfsr_en_o}),
                    128'({e.we, 1'b1, e.err, e.lfsr_en}));
                if (e.we) begin
                    chk("write_way", 128'(refill_way_o), 128'(e.way));
                    chk("write_idx_tag", 128'({refill_tag_o, refill_idx_o}), 128'({e.tag, e.idx}));
                    chk("write_data", refill_data_o, e.data);
                end
            end
        end
    end

    // Drive one miss from acceptance to completion; called at posedge+1 with the DUT idle.
    task automatic run_txn(input txn_t t);
        exp_t e;
        bit   used;
        int   guard;
        guard = 0;
        while (!miss_ready_o && guard < 20) begin
            @(posedge clk_i); #1;
            guard++;
        end
        chk("ready_before_miss", 128'(miss_ready_o), 128'(1));
        miss_valid_i = 1'b1;
        miss_idx_i   = t.idx;
        miss_tag_i   = t.tag;
        @(posedge clk_i); #1;
        miss_valid_i = 1'b0;
        miss_idx_i   = IDX_W'($urandom);
        miss_tag_i   = TAG_W'($urandom);
        last_tag     = t.tag;
        for (int c = 0; c <= t.req_wait; c++) begin
            if (c == t.req_wait) mem_req_ready_i = 1'b1;
            if (t.kind == 1 && c == t.flush_at) flush_i = 1'b1;
            @(negedge clk_i);
            chk("req_valid", 128'(mem_req_valid_o), 128'(1));
            chk("req_addr", 128'(mem_req_addr_o), 128'({t.tag, t.idx}));
            @(posedge clk_i); #1;
            mem_req_ready_i = 1'b0;
            flush_i         = 1'b0;
        end
        if (t.kind == 2) begin
            flush_i = 1'b1;
            @(posedge clk_i); #1;
            flush_i = 1'b0;
        end
        for (int c = 0; c < t.rsp_wait; c++) begin
            @(negedge clk_i);
            chk("busy_waiting", 128'({busy_o, mem_req_valid_o}), 128'(2'b10));
            @(posedge clk_i); #1;
        end
        if (t.kind == 0) begin
            e.we  = !t.err;
            e.err = t.err;
            pick_way(t.vb, t.lfsr, e.way, used);
            e.lfsr_en = !t.err && used;
            e.idx  = t.idx;
            e.tag  = t.tag;
            e.data = t.data;
            sb.push_back(e);
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_err_i   = t.err;
        mem_rsp_data_i  = t.data;
        valid_bits_i    = t.vb;
        lfsr_way_i      = t.lfsr;
        if (t.kind == 3) flush_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'($urandom);
        mem_rsp_data_i  = rand_line();
        valid_bits_i    = N_WAY'($urandom);
        lfsr_way_i      = WAY_W'($urandom);
        flush_i         = 1'b0;
        if (t.kind == 0 && !t.err) begin
            @(negedge clk_i);
            chk("we_latency", 128'(refill_we_o), 128'(1));
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        chk("idle_after", 128'({miss_ready_o, busy_o}), 128'(2'b10));
        @(posedge clk_i); #1;
    endtask

    function automatic txn_t mk(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                                input logic [N_WAY-1:0] vb, input logic [WAY_W-1:0] lfsr,
                                input bit err, input int kind, input int req_wait,
                                input int flush_at, input int rsp_wait);
        txn_t t;
        t.idx = idx; t.tag = tag; t.vb = vb; t.lfsr = lfsr; t.err = err;
        t.data = rand_line(); t.kind = kind; t.req_wait = req_wait;
        t.flush_at = flush_at; t.rsp_wait = rsp_wait;
        return t;
    endfunction

    initial begin
        txn_t t;
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        miss_valid_i    = 1'b0;
        miss_idx_i      = '0;
        miss_tag_i      = '0;
        valid_bits_i    = '0;
        lfsr_way_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_data_i  = '0;

        @(negedge clk_i);
        chk("rst_ready", 128'(miss_ready_o), 128'(1));
        chk("rst_ctrl", 128'({mem_req_valid_o, refill_we_o, refill_done_o, refill_err_o, lfsr_en_o, busy_o}), 128'(0));
        chk("rst_regs", 128'({refill_way_o, refill_idx_o, refill_tag_o, mem_req_addr_o}), 128'(0));
        chk("rst_data", refill_data_o, 128'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Invalid way 2 chosen, no LFSR advance
        run_txn(mk(6'h05, 20'hABCDE, 4'b1011, 2'd0, 1'b0, 0, 0, 0, 3));
        // Full set: LFSR way 3 and LFSR advance
        run_txn(mk(6'h05, 20'hABCDE, 4'b1111, 2'd3, 1'b0, 0, 0, 0, 3));
        // Request stalled 5 cycles, flush mid-stall: response discarded
        run_txn(mk(6'h11, 20'h12345, 4'b0000, 2'd1, 1'b0, 1, 5, 2, 2));
        // Bus error completion
        run_txn(mk(6'h22, 20'h0BEEF, 4'b0111, 2'd2, 1'b1, 0, 1, 0, 1));
        // Flush in WAIT, flush coincident with response
        run_txn(mk(6'h33, 20'hFACE0, 4'b1110, 2'd0, 1'b0, 2, 0, 0, 1));
        run_txn(mk(6'h34, 20'hFACE1, 4'b1110, 2'd0, 1'b0, 3, 0, 0, 2));

        // Flush and miss together in IDLE: miss refused and not latched
        flush_i      = 1'b1;
        miss_valid_i = 1'b1;
        miss_idx_i   = 6'h3F;
        miss_tag_i   = 20'h55555;
        @(negedge clk_i);
        chk("flush_blocks_ready", 128'(miss_ready_o), 128'(0));
        @(posedge clk_i); #1;
        flush_i      = 1'b0;
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_no_accept", 128'({busy_o, mem_req_valid_o}), 128'(0));
        chk("flush_no_latch", 128'(refill_tag_o), 128'(last_tag));
        @(posedge clk_i); #1;

        // Reset while waiting for the response
        miss_valid_i = 1'b1;
        miss_idx_i   = 6'h2A;
        miss_tag_i   = 20'h77777;
        @(posedge clk_i); #1;
        miss_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_req_ready_i = 1'b0;
        @(negedge clk_i);
        chk("wait_busy", 128'({busy_o, mem_req_valid_o}), 128'(2'b10));
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_ctrl", 128'({miss_ready_o, mem_req_valid_o, refill_we_o, refill_done_o, refill_err_o, lfsr_en_o, busy_o}), 128'(7'b1000000));
        chk("midrst_regs", 128'({refill_way_o, refill_idx_o, refill_tag_o, refill_data_o[15:0]}), 128'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_txn(mk(6'h2A, 20'h77777, 4'b1101, 2'd0, 1'b0, 0, 0, 0, 1));

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 9);
            t = mk(IDX_W'($urandom), TAG_W'($urandom),
                   ($urandom_range(0, 2) == 0) ? 4'hF : N_WAY'($urandom),
                   WAY_W'($urandom), ($urandom_range(0, 3) == 0),
                   (k >= 6 && k <= 8) ? k - 5 : 0,
                   $urandom_range(0, 4), 0, $urandom_range(0, 4));
            t.flush_at = $urandom_range(0, t.req_wait);
            run_txn(t);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
